// File: rtl/inst_encoder_if.sv
// inst_encoder_if
//
// Purpose: groups the request and response handshakes of the RV32I
// instruction encoder into one bundle.
//
// Signals:
//   in_valid / in_ready      request handshake (producer -> encoder)
//   op_sel                   operation select (0..8 valid, 9..15 invalid)
//   rd, rs1, rs2, funct3     register and funct3 fields of the request
//   imm                      32-bit immediate (byte offset for BRANCH/JAL)
//   out_valid / out_ready    response handshake (encoder -> consumer)
//   out_inst                 encoded 32-bit instruction word
//   out_last                 final word of the current request
//   err                      error flag for the current word
//
// Modports:
//   master  the side issuing requests and consuming encoded words
//   slave   the encoder itself
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        err;

    modport master (
        output in_valid, op_sel, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_last, err
    );

    modport slave (
        input  in_valid, op_sel, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_inst, out_last, err
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder
//
// Purpose: encodes one RV32I instruction per accepted request into a
// registered 32-bit word. The LI pseudo-op expands to ADDI, LUI, or a
// LUI + ADDI pair; the second word of a pair is only produced after the
// first has been taken by the consumer.
//
// Parameters:
//   RESET_INST  out_inst value after reset and for invalid op_sel (NOP)
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   inst_encoder_if.slave: request handshake and fields in,
//         encoded word with out_last/err out
//
// Build option:
//   IMM_RANGE_CHECK_EN  when defined, err is also raised alongside any word
//                       whose immediate does not fit its format. Without it
//                       immediates are truncated silently.
module inst_encoder #(
    parameter logic [31:0] RESET_INST = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] SEL_OPIMM  = 4'd0;
    localparam logic [3:0] SEL_LOAD   = 4'd1;
    localparam logic [3:0] SEL_STORE  = 4'd2;
    localparam logic [3:0] SEL_BRANCH = 4'd3;
    localparam logic [3:0] SEL_AUIPC  = 4'd4;
    localparam logic [3:0] SEL_LUI    = 4'd5;
    localparam logic [3:0] SEL_JAL    = 4'd6;
    localparam logic [3:0] SEL_JALR   = 4'd7;
    localparam logic [3:0] SEL_LI     = 4'd8;

    typedef enum logic {
        IDLE  = 1'b0,
        LI_LO = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic        out_last_q;
    logic        err_q;
    logic [4:0]  li_rd_q;
    logic [11:0] li_lo_q;

    logic        in_ready_c;
    logic        accept;
    logic        out_fire;
    logic [31:0] enc_inst;
    logic        enc_last;
    logic        enc_err;
    logic        enc_two;
    logic        range_err;
    logic        imm_fits12;
    logic [19:0] li_hi;

    assign accept   = bus.in_valid && in_ready_c;
    assign out_fire = out_valid_q && bus.out_ready;

    assign imm_fits12 = (bus.imm[31:11] == 21'h000000) ||
                        (bus.imm[31:11] == 21'h1FFFFF);

    // Upper part of a split LI: the ADDI that follows sign-extends imm[11:0],
    // so bit 11 acts as a carry into the LUI value ((imm + 0x800) >> 12).
    assign li_hi = bus.imm[31:12] + {19'd0, bus.imm[11]};

`ifdef IMM_RANGE_CHECK_EN
    logic imm_fits13;
    logic imm_fits21;

    assign imm_fits13 = (bus.imm[31:12] == 20'h00000) ||
                        (bus.imm[31:12] == 20'hFFFFF);
    assign imm_fits21 = (bus.imm[31:20] == 12'h000) ||
                        (bus.imm[31:20] == 12'hFFF);

    // LI is never flagged because it always expands to an exact sequence.
    always_comb begin
        range_err = 1'b0;
        case (bus.op_sel)
            SEL_OPIMM, SEL_LOAD,
            SEL_STORE, SEL_JALR: range_err = !imm_fits12;
            SEL_BRANCH:          range_err = !imm_fits13 || bus.imm[0];
            SEL_JAL:             range_err = !imm_fits21 || bus.imm[0];
            SEL_AUIPC, SEL_LUI:  range_err = (bus.imm[11:0] != 12'h000);
            default:             range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Combinational encoder for the first (or only) word of a request.
    always_comb begin
        enc_inst = RESET_INST;
        enc_last = 1'b1;
        enc_err  = range_err;
        enc_two  = 1'b0;
        case (bus.op_sel)
            SEL_OPIMM:  enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_OPIMM};
            SEL_LOAD:   enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_LOAD};
            SEL_STORE:  enc_inst = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                                    bus.imm[4:0], OPC_STORE};
            SEL_BRANCH: enc_inst = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                    bus.imm[4:1], bus.imm[11], OPC_BRANCH};
            SEL_AUIPC:  enc_inst = {bus.imm[31:12], bus.rd, OPC_AUIPC};
            SEL_LUI:    enc_inst = {bus.imm[31:12], bus.rd, OPC_LUI};
            SEL_JAL:    enc_inst = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                                    bus.rd, OPC_JAL};
            SEL_JALR:   enc_inst = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_JALR};
            SEL_LI: begin
                enc_err = 1'b0;
                if (imm_fits12) begin
                    enc_inst = {bus.imm[11:0], 5'd0, 3'b000, bus.rd, OPC_OPIMM};
                end else if (bus.imm[11:0] == 12'h000) begin
                    enc_inst = {bus.imm[31:12], bus.rd, OPC_LUI};
                end else begin
                    enc_inst = {li_hi, bus.rd, OPC_LUI};
                    enc_last = 1'b0;
                    enc_two  = 1'b1;
                end
            end
            default: begin
                enc_inst = RESET_INST;
                enc_err  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // LI_LO covers both words of a split LI; out_last tells which one is
    // currently presented, so only the final word's handshake returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && enc_two) state_next = LI_LO;
            LI_LO:   if (out_fire && out_last_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output process: request side is only open in IDLE with a free output slot.
    always_comb begin
        in_ready_c    = !rst && (state == IDLE) && (!out_valid_q || bus.out_ready);
        bus.in_ready  = in_ready_c;
        bus.out_valid = out_valid_q;
        bus.out_inst  = out_inst_q;
        bus.out_last  = out_last_q;
        bus.err       = err_q;
    end

    // Output word register. Reset wins over any handshake, which also drops a
    // pending second LI word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= RESET_INST;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= enc_inst;
            out_last_q  <= enc_last;
            err_q       <= enc_err;
        end else if ((state == LI_LO) && out_fire && !out_last_q) begin
            out_inst_q <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, OPC_OPIMM};
            out_last_q <= 1'b1;
            err_q      <= 1'b0;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    // Fields for the ADDI half of a split LI, captured when the request is taken.
    always_ff @(posedge clk) begin
        if (accept) begin
            li_rd_q <= bus.rd;
            li_lo_q <= bus.imm[11:0];
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
//
// Purpose: self-checking bench for inst_encoder. Requests are issued with
// hand-computed expected words pushed into a scoreboard queue; an
// independent monitor pops and compares every word the encoder hands over.
// Build option IMM_RANGE_CHECK_EN selects the expected err for out-of-range
// immediates.
module tb_inst_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] inst;
        logic        last;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   next_tag = 0;
    exp_t sb[$];
    exp_t mon_e;

    inst_encoder_if bus ();

    inst_encoder #(
        .RESET_INST(32'h00000013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic expectWord(input logic [31:0] inst, input logic last, input logic err);
        exp_t e;
        e.tag  = next_tag[7:0];
        e.inst = inst;
        e.last = last;
        e.err  = err;
        next_tag++;
        sb.push_back(e);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd_v,
                                 input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                 input logic [2:0] f3_v, input logic [31:0] imm_v);
        int   waited;
        logic got;
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.rd       = rd_v;
        bus.rs1      = rs1_v;
        bus.rs2      = rs2_v;
        bus.funct3   = f3_v;
        bus.imm      = imm_v;
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 40) begin
            #1;
            got = bus.in_ready;
            @(negedge clk);
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: op_sel=%0d not accepted within %0d cycles",
                     op, waited);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words still expected, required 0", sb.size());
        end
    endtask

    // Monitor: compares each word handed over against the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got inst=%h last=%b err=%b, required no word",
                         bus.out_inst, bus.out_last, bus.err);
            end else begin
                mon_e = sb.pop_front();
                checkOutput($sformatf("word%0d_inst", mon_e.tag), bus.out_inst, mon_e.inst);
                checkOutput($sformatf("word%0d_last", mon_e.tag), {31'd0, bus.out_last},
                            {31'd0, mon_e.last});
                checkOutput($sformatf("word%0d_err", mon_e.tag), {31'd0, bus.err},
                            {31'd0, mon_e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_sel    = 4'd0;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.funct3    = 3'd0;
        bus.imm       = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_inst", bus.out_inst, 32'h00000013);
        checkOutput("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // OP-IMM with one-cycle latency check
        expectWord(32'hFFF30293, 1'b1, 1'b0);
        applyStimulus(4'd0, 5'd5, 5'd6, 5'd0, 3'b000, 32'hFFFFFFFF);
        #1;
        checkOutput("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);

        // Back-to-back burst; unused fields carry junk that must not leak
        expectWord(32'h00712423, 1'b1, 1'b0);
        applyStimulus(4'd2, 5'd31, 5'd2, 5'd7, 3'b010, 32'h00000008);
        expectWord(32'hFFDFF0EF, 1'b1, 1'b0);
        applyStimulus(4'd6, 5'd1, 5'd31, 5'd31, 3'b111, 32'hFFFFFFFC);
        expectWord(32'h0104A403, 1'b1, 1'b0);
        applyStimulus(4'd1, 5'd8, 5'd9, 5'd31, 3'b010, 32'h00000010);
        expectWord(32'h004280E7, 1'b1, 1'b0);
        applyStimulus(4'd7, 5'd1, 5'd5, 5'd31, 3'b011, 32'h00000004);
        expectWord(32'h00001217, 1'b1, 1'b0);
        applyStimulus(4'd4, 5'd4, 5'd31, 5'd31, 3'b111, 32'h00001000);
        expectWord(32'h123451B7, 1'b1, 1'b0);
        applyStimulus(4'd5, 5'd3, 5'd31, 5'd31, 3'b111, 32'h12345000);
        expectWord(32'h06400393, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd7, 5'd31, 5'd31, 3'b111, 32'd100);
        expectWord(32'h7FF00093, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd1, 5'd0, 5'd0, 3'b000, 32'h000007FF);
        expectWord(32'h80000093, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFFF800);
        expectWord(32'h7FFFF137, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd2, 5'd0, 5'd0, 3'b000, 32'h7FFFF000);
        expectWord(32'h000010B7, 1'b0, 1'b0);
        expectWord(32'h80008093, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd1, 5'd0, 5'd0, 3'b000, 32'h00000800);
        expectWord(32'h80419063, 1'b1, RC);
        applyStimulus(4'd3, 5'd31, 5'd3, 5'd4, 3'b001, 32'h00001001);
        expectWord(32'h80000083, 1'b1, RC);
        applyStimulus(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 32'h00000800);
        expectWord(32'h0020006F, 1'b1, RC);
        applyStimulus(4'd6, 5'd0, 5'd0, 5'd0, 3'b000, 32'h00000003);
        expectWord(32'h00000217, 1'b1, RC);
        applyStimulus(4'd4, 5'd4, 5'd0, 5'd0, 3'b000, 32'h00000123);
        expectWord(32'h00000013, 1'b1, 1'b1);
        applyStimulus(4'd12, 5'd3, 5'd3, 5'd3, 3'b011, 32'h00000555);
        expectWord(32'h00000013, 1'b1, 1'b1);
        applyStimulus(4'd9, 5'd1, 5'd1, 5'd1, 3'b001, 32'h00000001);
        drain();

        // Single-word backpressure closes the request side
        bus.out_ready = 1'b0;
        expectWord(32'hFFF30293, 1'b1, 1'b0);
        applyStimulus(4'd0, 5'd5, 5'd6, 5'd0, 3'b000, 32'hFFFFFFFF);
        #1;
        checkOutput("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        drain();

        // Split LI held under backpressure
        bus.out_ready = 1'b0;
        expectWord(32'h12346537, 1'b0, 1'b0);
        expectWord(32'hFFF50513, 1'b1, 1'b0);
        applyStimulus(4'd8, 5'd10, 5'd0, 5'd0, 3'b000, 32'h12345FFF);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("li_hold%0d_inst", i), bus.out_inst, 32'h12346537);
            checkOutput($sformatf("li_hold%0d_last", i), {31'd0, bus.out_last}, 32'd0);
            checkOutput($sformatf("li_hold%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("li_first_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("li_second_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("li_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("li_done_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        drain();

        // Reset while the first LI word waits; the ADDI half must never appear
        bus.out_ready = 1'b0;
        applyStimulus(4'd8, 5'd10, 5'd0, 5'd0, 3'b000, 32'h12345FFF);
        #1;
        checkOutput("rstli_out_valid_before", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rstli_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rstli_in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rstli_out_inst", bus.out_inst, 32'h00000013);
        checkOutput("rstli_out_last", {31'd0, bus.out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("rstli_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("rstli_out_valid_quiet", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);

        // Normal operation after reset
        expectWord(32'h00712423, 1'b1, 1'b0);
        applyStimulus(4'd2, 5'd0, 5'd2, 5'd7, 3'b010, 32'h00000008);
        drain();
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter RESET_INST, default 32'h00000013 (NOP), the out_inst value after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port op_sel  input  4  0 OP-IMM, 1 LOAD, 2 STORE, 3 BRANCH, 4 AUIPC, 5 LUI, 6 JAL, 7 JALR, 8 LI pseudo-op, 9-15 invalid.
REQ-007 SHALL have ports rd, rs1, rs2  input  5 each  register fields.
REQ-008 SHALL have port funct3  input  3  funct3 field.
REQ-009 SHALL have port imm  input  32  immediate value, byte offset for BRANCH and JAL.
REQ-010 SHALL have port out_valid  output  1  out_inst holds a valid word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-012 SHALL have port out_inst  output  32  encoded instruction.
REQ-013 SHALL have port out_last  output  1  final word of the current request.
REQ-014 SHALL have port err  output  1  error flag for the current word.

Function
REQ-015 SHALL use these opcodes: OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, AUIPC 0010111, LUI 0110111, JAL 1101111, JALR 1100111.
REQ-016 SHALL place rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20] for the formats that use them; unused fields SHALL be 0.
REQ-017 SHALL pack the immediate as follows:
- I-type: imm[11:0] into [31:20].
- S-type: imm[11:5] into [31:25], imm[4:0] into [11:7].
- B-type: imm[12|10:5] into [31:25], imm[4:1|11] into [11:7].
- U-type: imm[31:12] into [31:12].
- J-type: imm[20|10:1|11|19:12] into [31:12].
- imm[0] is ignored for B and J.
REQ-018 SHALL force funct3 to 000 for JALR.
REQ-019 SHALL register the output with 1-cycle latency: a request accepted at edge N gives out_valid=1 after edge N.
REQ-020 SHALL hold out_inst, out_last and err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive in_ready=1 only in state IDLE and only when out_valid=0 or out_ready=1, allowing back-to-back requests at one per cycle.
REQ-022 SHALL use a state machine with states IDLE and LI_LO.
- Accepting an LI request that needs two words SHALL move IDLE to LI_LO.
- Handshake of the second word SHALL move LI_LO back to IDLE.
REQ-023 SHALL encode LI as follows:
- If imm fits signed 12 bits: one word, ADDI rd,x0,imm.
- Else if imm[11:0]=0: one word, LUI rd,imm[31:12].
- Else: two words, LUI rd,hi with hi=(imm+32'h800)>>12 (mod 2^32), then ADDI rd,rd,imm[11:0].
REQ-024 SHALL emit the second LI word only after the first word's handshake, capturing rd and imm[11:0] at acceptance.
REQ-025 SHALL drive out_last=1 on single-word requests and on the final LI word, and 0 on the first of two LI words.
REQ-026 SHALL emit RESET_INST with out_last=1 and err=1 for an invalid op_sel, regardless of the configuration macro.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set state=IDLE, out_valid=0, out_inst=RESET_INST, out_last=0, err=0.
REQ-028 SHALL discard any pending LI second word on reset; rst takes priority over a simultaneous handshake.
REQ-029 SHALL hold in_ready=0 while rst=1.

Configuration
REQ-030 SHALL, with IMM_RANGE_CHECK_EN defined, set err=1 alongside the word when the immediate does not fit its format; the word is still emitted with truncated fields. Checks:
- I/S: signed 12 bits.
- B: signed 13 bits and even.
- J: signed 21 bits and even.
- U: imm[11:0]=0.
- LI: never flagged.
REQ-031 SHALL, without IMM_RANGE_CHECK_EN, truncate silently with no range-check logic, err being 1 only per REQ-026.

Verification
REQ-032 SHALL cover OP-IMM rd=5, rs1=6, funct3=000, imm=-1 -> out_inst 0xFFF30293, out_last=1, err=0, one cycle after acceptance.
REQ-033 SHALL cover STORE rs1=2, rs2=7, funct3=010, imm=8 -> out_inst 0x00712423.
REQ-034 SHALL cover JAL rd=1, imm=0xFFFFFFFC -> out_inst 0xFFDFF0EF.
REQ-035 SHALL cover LI rd=10, imm=0x12345FFF with out_ready held low for 3 cycles -> 0x12346537 (out_last=0) held stable, then 0xFFF50513 (out_last=1); in_ready=0 throughout.
REQ-036 SHALL cover BRANCH imm=0x1001 -> err=1 with IMM_RANGE_CHECK_EN defined, err=0 without it; op_sel=12 -> 0x00000013 with err=1 in both builds.
REQ-037 SHALL cover rst=1 while the first LI word waits with out_ready=0 -> next cycle out_valid=0; after release in_ready=1 and no ADDI word is ever emitted.
